// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, MSB first with early exit on the first differing bit.
// Result flags are held until the next accepted start; a start in DONE chains with no idle gap.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IW-1:0]    idx;
  logic             bit_eq;
  logic             accept;

  assign bit_eq = ~(a_sh[WIDTH-1] ^ b_sh[WIDTH-1]);
  assign accept = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = (!bit_eq || idx == '0) ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands shift left so the bit under test is always at the MSB position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      idx  <= '0;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      idx  <= IW'(WIDTH - 1);
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else if (state == RUN) begin
      if (!bit_eq) begin
        gt <= a_sh[WIDTH-1];
        lt <= ~a_sh[WIDTH-1];
      end else if (idx == '0) begin
        eq <= 1'b1;
      end else begin
        idx  <= idx - IW'(1);
        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp (WIDTH=8): expected flags and done latency are queued
// at each start and popped when done is observed.
module tb_serial_mag_comp;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       eq;
  logic       gt;
  logic       lt;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_mag_comp #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: flags from integer compare; latency from the highest differing bit.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.flags = (av == bv) ? 3'b100 : (av > bv) ? 3'b010 : 3'b001;
    e.lat   = 9;
    for (int i = 0; i < 8; i++) begin
      if (av[i] != bv[i]) e.lat = 8 - i + 1;
    end
    return e;
  endfunction

  // Drives start in the current cycle (cycle 0); cycle-1 inputs are s1/a1/b1.
  task automatic run(input logic [7:0] av, input logic [7:0] bv,
                     input logic s1, input logic [7:0] a1, input logic [7:0] b1,
                     input logic post_idle);
    exp_t e;
    bit   found;
    a     = av;
    b     = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    found = 1'b0;
    for (int c = 1; c <= 12 && !found; c++) begin
      tick();
      if (done === 1'b1) begin
        found = 1'b1;
        e = sb.pop_front();
        check("done_latency", c, e.lat);
        check("result_flags", {eq, gt, lt}, e.flags);
        check("busy_in_done", busy, 1'b0);
      end else begin
        check("run_state", {busy, eq, gt, lt}, 4'b1000);
        if (c == 1) begin
          start = s1;
          a     = a1;
          b     = b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!found) begin
      check("done_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) e = sb.pop_front();
    end
    if (post_idle) begin
      start = 1'b0;
      tick();
      check("idle_after_done", {busy, done}, 2'b00);
      check("flags_held", {eq, gt, lt}, e.flags);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_async", {busy, done, eq, gt, lt}, 5'b0);
    tick();
    tick();
    check("reset_held", {busy, done, eq, gt, lt}, 5'b0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {busy, done, eq, gt, lt}, 5'b0);

    run(8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1);
    run(8'h80, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b1);
    run(8'h12, 8'h13, 1'b0, 8'h00, 8'h00, 1'b1);
    // Second start during RUN with different operands must be ignored.
    run(8'h40, 8'h20, 1'b1, 8'h00, 8'hFF, 1'b1);
    run(8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset in the middle of a comparison aborts with no done pulse.
    a     = 8'h01;
    b     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("busy_before_abort", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_async", {busy, done, eq, gt, lt}, 5'b0);
    tick();
    check("abort_no_done", {busy, done, eq, gt, lt}, 5'b0);
    rst_n = 1'b1;
    run(8'h03, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1);

    // Back-to-back: second start issued in the DONE cycle of the first.
    run(8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
